nibble_sum_accumulator: RTL and testbench
=========================================

Name: nibble_sum_accumulator

Overview:
Downstream consumer of the 4-bit operand-pair adder stage. Accepts operand pairs over a valid/ready handshake and forms each pair sum at full width (DATA_W+1). Accumulates BURST pair sums into an ACC_W total, then presents the total on a valid/ready output with an overflow flag. Sits between the operand source and the result sink.

Parameters:
DATA_W, 4, operand width (in_a, in_b).
ACC_W, 8, accumulator and result width; must be >= DATA_W+1.
BURST, 4, pairs per result; must be >= 1. Counter width is $clog2(BURST+1).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept a pair.
in_a  input  DATA_W  operand A.
in_b  input  DATA_W  operand B.
out_valid  output  1  result valid.
out_ready  input  1  sink accepts result.
out_sum  output  ACC_W  accumulated total of BURST pair sums.
out_ovf  output  1  total exceeded 2^ACC_W-1 during this burst.
busy  output  1  state != IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset values: state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0, in_ready=1, busy=0.
- FSM states:
  - IDLE: no pairs held. On accept, go to ACCUM, or straight to HOLD if BURST==1.
  - ACCUM: 1..BURST-1 pairs taken. On the accept of pair number BURST, go to HOLD.
  - HOLD: result presented. On out_valid && out_ready, go to IDLE.
- Accept: in_valid && in_ready. in_ready = (state != HOLD), registered-state decode, no combinational path from out_ready.
- Pair sum: zero-extend a and b to DATA_W+1 bits, then add. Never truncated.
- Accumulate: acc_next = acc + zext(pair_sum) at ACC_W+1 bits. Bit ACC_W set means overflow; set ovf sticky for the burst.
- Latency: out_valid rises the cycle after the BURST-th accept. out_sum and out_ovf are registered and stable while out_valid=1 && out_ready=0.
- Output handshake: clears acc, cnt and ovf, and drops out_valid next cycle. No input accepted in HOLD, so no simultaneous accept/emit. Steady-state throughput is one result per BURST+1 cycles.
- in_valid low in ACCUM: hold acc and cnt indefinitely. No timeout.
- Reset mid-burst: partial acc is discarded and the next burst starts from 0.
- X on in_a/in_b when in_valid=0 must not propagate into acc.

Optional Feature:
NIBBLE_ACC_SAT_EN
- Defined: accumulation saturates. When acc_next[ACC_W] is set, acc becomes 2^ACC_W-1 and stays there for the rest of the burst. out_ovf=1.
- Undefined: accumulation wraps modulo 2^ACC_W. out_ovf=1 if any wrap occurred in the burst.
- Port list is identical in both builds.

Decomposition:
- Package nibble_acc_pkg: state enum typedef (IDLE, ACCUM, HOLD) and default width constants.
- Sub-module nibble_pair_adder: combinational, DATA_W in, DATA_W+1 out. It is the single place for the zero-extend rule and is reused by the neighbouring adder stage.
- FSM, counter and accumulator stay in the top module.

Test Plan:
- Basic burst, defaults: pairs (2,2),(3,4),(15,15),(1,0) back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_sum=42 (0x2A), out_ovf=0.
- Overflow, ACC_W=6: four pairs (15,15) -> wrap build gives out_sum=56, out_ovf=1; NIBBLE_ACC_SAT_EN build gives out_sum=63, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_sum and out_ovf stable, in_ready=0 throughout, in_valid=1 pairs not accepted. Release -> IDLE next cycle.
- Input gaps: in_valid toggles 1,0,0,1,0,1,1 with pairs (1,1) -> total 8 after 4 accepts, cnt unchanged on idle cycles.
- Reset mid-burst: accept (7,7),(7,7), pulse rst_n low asynchronously between edges -> all outputs at reset values immediately. Next burst of four (1,2) -> out_sum=12.
- BURST=1: continuous in_valid, out_ready=1 with pair (9,9) -> out_sum=18 every 2 cycles, in_ready alternating 1/0.

Source files
------------

// File: rtl/nibble_acc_pkg.sv
// Shared definitions for the nibble sum accumulator slice.
//
// Contents:
//   DEF_DATA_W, DEF_ACC_W, DEF_BURST - default widths and burst length
//   acc_state_t                      - accumulator FSM state encoding
//
// Optional build macro used by the slice: NIBBLE_ACC_SAT_EN (see top module).
package nibble_acc_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W  = 8;
    localparam int DEF_BURST  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/nibble_pair_adder.sv
// Combinational operand-pair adder.
//
// Both operands are zero-extended to DATA_W+1 bits before the add, so the
// carry out of the top bit is always kept. This module is the single home of
// that rule and is shared with the neighbouring adder stage.
//
// Ports:
//   a   [DATA_W-1:0] in  - operand A
//   b   [DATA_W-1:0] in  - operand B
//   sum [DATA_W:0]   out - full-width pair sum
module nibble_pair_adder
    import nibble_acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/nibble_sum_accumulator.sv
// Nibble sum accumulator.
//
// Takes operand pairs over a valid/ready handshake, adds each pair at full
// width, and accumulates BURST pair sums into an ACC_W total. The total is
// then presented on a valid/ready output together with an overflow flag.
// No pair is accepted while a result is waiting, so accept and emit never
// happen in the same cycle.
//
// Build option:
//   NIBBLE_ACC_SAT_EN defined   - the accumulator saturates at 2^ACC_W-1 on
//                                 overflow and stays there for the burst.
//   NIBBLE_ACC_SAT_EN undefined - the accumulator wraps modulo 2^ACC_W.
//   In both builds out_ovf reports whether the burst overflowed.
//
// Ports:
//   clk       in  - clock, rising edge
//   rst_n     in  - asynchronous active-low reset
//   in_valid  in  - operand pair valid
//   in_ready  out - pair can be accepted (low while a result is held)
//   in_a      in  - operand A [DATA_W-1:0]
//   in_b      in  - operand B [DATA_W-1:0]
//   out_valid out - result valid
//   out_ready in  - sink accepts result
//   out_sum   out - accumulated total [ACC_W-1:0]
//   out_ovf   out - total exceeded 2^ACC_W-1 during this burst
//   busy      out - FSM is not idle
module nibble_sum_accumulator
    import nibble_acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int BURST  = DEF_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [DATA_W:0]  pair_sum;
    logic [ACC_W:0]   pair_ext;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_new;
    logic             ovf_new;
    logic             accept;

    nibble_pair_adder #(
        .DATA_W (DATA_W)
    ) u_pair_adder (
        .a   (in_a),
        .b   (in_b),
        .sum (pair_sum)
    );

    // Both handshake outputs decode only the registered state, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready = (state != HOLD);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // ACC_W >= DATA_W+1 guarantees at least one padding bit here.
    assign pair_ext = {{(ACC_W - DATA_W){1'b0}}, pair_sum};

    // One extra bit on the add exposes the carry that marks overflow; the
    // overflow flag is sticky across the burst.
    always_comb begin
        acc_sum = {1'b0, acc} + pair_ext;
        ovf_new = ovf | acc_sum[ACC_W];
`ifdef NIBBLE_ACC_SAT_EN
        acc_new = ovf_new ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
        acc_new = acc_sum[ACC_W-1:0];
`endif
    end

    // Accumulator FSM. acc and ovf only move on an accepted pair, so operand
    // values present while in_valid is low never reach the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= acc_new;
                        ovf <= ovf_new;
                        if (cnt == LAST_CNT) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_sum   <= acc_new;
                            out_ovf   <= ovf_new;
                        end else begin
                            state <= ACCUM;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sum_accumulator.sv
// Testbench for nibble_sum_accumulator.
//
// Three instances share clock and reset: the default configuration, an
// ACC_W=6 instance for overflow, and a BURST=1 instance. Expected results
// for the default instance come from a small behavioural model that pushes
// totals into a queue; they are popped when out_valid rises.
// Expected values for the overflow instance follow NIBBLE_ACC_SAT_EN.
module tb_nibble_sum_accumulator;

    typedef struct {
        logic       valid;
        logic [3:0] a;
        logic [3:0] b;
        logic       out_ready;
        logic       exp_in_ready;
        logic       exp_out_valid;
        logic       exp_busy;
    } vec_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       ovf;
    } res_t;

    logic clk;
    logic rst_n;

    // default instance
    logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_ovf, d_busy;
    logic [3:0] d_a, d_b;
    logic [7:0] d_out_sum;

    // ACC_W=6 instance
    logic       o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_out_ovf, o_busy;
    logic [3:0] o_a, o_b;
    logic [5:0] o_out_sum;

    // BURST=1 instance
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf, s_busy;
    logic [3:0] s_a, s_b;
    logic [7:0] s_out_sum;

    int   errors = 0;
    int   checks = 0;

    res_t exp_q[$];
    res_t held;
    logic d_prev_valid;
    int   m_acc;
    int   m_cnt;
    logic m_hold;

    vec_t vecs[24];
    vec_t rvec;

    nibble_sum_accumulator u_def (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_a(d_a), .in_b(d_b),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_sum(d_out_sum), .out_ovf(d_out_ovf), .busy(d_busy)
    );

    nibble_sum_accumulator #(.DATA_W(4), .ACC_W(6), .BURST(4)) u_ovf (
        .clk(clk), .rst_n(rst_n),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .in_a(o_a), .in_b(o_b),
        .out_valid(o_out_valid), .out_ready(o_out_ready),
        .out_sum(o_out_sum), .out_ovf(o_out_ovf), .busy(o_busy)
    );

    nibble_sum_accumulator #(.DATA_W(4), .ACC_W(8), .BURST(1)) u_b1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_a), .in_b(s_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_ovf(s_out_ovf), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        d_in_valid  = v.valid;
        d_a         = v.a;
        d_b         = v.b;
        d_out_ready = v.out_ready;
    endtask

    // Reference model step for one clock edge of the default instance.
    task automatic modelEdge(input vec_t v);
        res_t r;
        if (m_hold) begin
            if (v.out_ready) m_hold = 1'b0;
        end else if (v.valid) begin
            m_acc = m_acc + int'(v.a) + int'(v.b);
            m_cnt++;
            if (m_cnt == 4) begin
`ifdef NIBBLE_ACC_SAT_EN
                r.sum = (m_acc > 255) ? 8'hFF : 8'(m_acc);
`else
                r.sum = 8'(m_acc % 256);
`endif
                r.ovf = (m_acc > 255);
                exp_q.push_back(r);
                m_hold = 1'b1;
                m_acc  = 0;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v);
        @(posedge clk);
        modelEdge(v);
        #2;
        checkOutput({tag, "_in_ready"},  32'(d_in_ready),  32'(v.exp_in_ready));
        checkOutput({tag, "_out_valid"}, 32'(d_out_valid), 32'(v.exp_out_valid));
        checkOutput({tag, "_busy"},      32'(d_busy),      32'(v.exp_busy));
        if (d_out_valid && !d_prev_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput({tag, "_unexpected_result"}, 32'(1), 32'(0));
            end else begin
                held = exp_q.pop_front();
                checkOutput({tag, "_out_sum"}, 32'(d_out_sum), 32'(held.sum));
                checkOutput({tag, "_out_ovf"}, 32'(d_out_ovf), 32'(held.ovf));
            end
        end else if (d_out_valid) begin
            checkOutput({tag, "_sum_stable"}, 32'(d_out_sum), 32'(held.sum));
            checkOutput({tag, "_ovf_stable"}, 32'(d_out_ovf), 32'(held.ovf));
        end
        d_prev_valid = d_out_valid;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"},  32'(d_in_ready),  32'(1));
        checkOutput({tag, "_busy"},      32'(d_busy),      32'(0));
        checkOutput({tag, "_out_valid"}, 32'(d_out_valid), 32'(0));
        checkOutput({tag, "_out_sum"},   32'(d_out_sum),   32'(0));
        checkOutput({tag, "_out_ovf"},   32'(d_out_ovf),   32'(0));
    endtask

    initial begin
        int  lat;
        logic odd;

        // basic burst: 4+7+30+1 = 42
        vecs[0]  = '{1'b1, 4'd2,  4'd2,  1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 4'd3,  4'd4,  1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 4'd1,  4'd0,  1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
        // backpressure: total 40 held for five cycles while in_valid=1
        vecs[5]  = '{1'b1, 4'd5,  4'd5,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 4'd5,  4'd5,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 4'd5,  4'd5,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 4'd5,  4'd5,  1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 9; i < 14; i++)
            vecs[i] = '{1'b1, 4'd8, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0};
        // input gaps 1,0,0,1,0,1,1 with (1,1); idle operands are X
        vecs[16] = '{1'b1, 4'd1,    4'd1,    1'b1, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 4'bxxxx, 4'bxxxx, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 4'bxxxx, 4'bxxxx, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 4'd1,    4'd1,    1'b1, 1'b1, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 4'bxxxx, 4'bxxxx, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[21] = '{1'b1, 4'd1,    4'd1,    1'b1, 1'b1, 1'b0, 1'b1};
        vecs[22] = '{1'b1, 4'd1,    4'd1,    1'b1, 1'b0, 1'b1, 1'b1};
        vecs[23] = '{1'b0, 4'd0,    4'd0,    1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        d_in_valid = 1'b0; d_a = '0; d_b = '0; d_out_ready = 1'b1;
        o_in_valid = 1'b0; o_a = '0; o_b = '0; o_out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
        m_acc = 0; m_cnt = 0; m_hold = 1'b0; d_prev_valid = 1'b0;
        held = '0;

        #11;
        checkResetValues("reset");
        #1 rst_n = 1'b1;

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 24; i++)
            runVector(vecs[i], $sformatf("v%0d", i));

        $display("[TB] reset mid-burst");
        rvec = '{1'b1, 4'd7, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1};
        runVector(rvec, "r7a");
        runVector(rvec, "r7b");
        rst_n = 1'b0;
        #1;
        checkResetValues("midrst");
        #1 rst_n = 1'b1;
        m_acc = 0; m_cnt = 0; m_hold = 1'b0; d_prev_valid = 1'b0;
        rvec = '{1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++)
            runVector(rvec, $sformatf("r12_%0d", i));
        rvec = '{1'b1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1};
        runVector(rvec, "r12_3");
        rvec = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        runVector(rvec, "r12_done");

        $display("[TB] overflow with ACC_W=6");
        @(negedge clk);
        o_in_valid = 1'b1; o_a = 4'd15; o_b = 4'd15;
        lat = 0;
        for (int k = 0; k < 8 && !o_out_valid; k++) begin
            @(posedge clk);
            #2;
            lat++;
            if (!o_out_valid)
                checkOutput("ovf_in_ready_accum", 32'(o_in_ready), 32'(1));
        end
        o_in_valid = 1'b0;
        checkOutput("ovf_out_valid", 32'(o_out_valid), 32'(1));
        checkOutput("ovf_latency", 32'(lat), 32'(4));
        checkOutput("ovf_in_ready_hold", 32'(o_in_ready), 32'(0));
`ifdef NIBBLE_ACC_SAT_EN
        checkOutput("ovf_out_sum", 32'(o_out_sum), 32'(63));
`else
        checkOutput("ovf_out_sum", 32'(o_out_sum), 32'(56));
`endif
        checkOutput("ovf_out_ovf", 32'(o_out_ovf), 32'(1));
        @(posedge clk);
        #2;
        checkOutput("ovf_released", 32'(o_out_valid), 32'(0));
        checkOutput("ovf_busy_idle", 32'(o_busy), 32'(0));

        $display("[TB] BURST=1 continuous");
        @(negedge clk);
        s_in_valid = 1'b1; s_a = 4'd9; s_b = 4'd9;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #2;
            odd = (k % 2 == 1);
            checkOutput($sformatf("b1_%0d_in_ready", k),  32'(s_in_ready),  32'(!odd));
            checkOutput($sformatf("b1_%0d_out_valid", k), 32'(s_out_valid), 32'(odd));
            checkOutput($sformatf("b1_%0d_busy", k),      32'(s_busy),      32'(odd));
            if (odd) begin
                checkOutput($sformatf("b1_%0d_out_sum", k), 32'(s_out_sum), 32'(18));
                checkOutput($sformatf("b1_%0d_out_ovf", k), 32'(s_out_ovf), 32'(0));
            end
        end
        s_in_valid = 1'b0;

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
